// File: rtl/lvds_7to1_tx_gearbox.sv
// 7:1 LVDS transmit gearbox: two 7-bit words per lane per 7-cycle period are
// serialized into 2-bit DDR chunks, with a matching 1100011 clock-lane pattern.
module lvds_7to1_tx_gearbox #(
  parameter int         LANES     = 4,
  parameter logic [6:0] IDLE_WORD = 7'h00
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 lock,
  input  logic [7*LANES-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*LANES-1:0]   out_data,
  output logic [1:0]           out_clk,
  output logic                 underflow
);

  localparam logic [2:0] PH_SLOT_A = 3'd6;
  localparam logic [2:0] PH_SLOT_B = 3'd2;

  logic       lock_meta;
  logic       lock_sync;
  logic [2:0] ph;
  logic [6:0] word_a [LANES];
  logic [6:0] word_b [LANES];
  logic       slot_a;
  logic       slot_b;

  // Serial order per period is {wB, wA}, two bits per phase, LSB first.
  function automatic logic [1:0] chunk_sel(input logic [2:0] p,
                                           input logic [6:0] a,
                                           input logic [6:0] b);
    case (p)
      3'd0:    chunk_sel = {a[1], a[0]};
      3'd1:    chunk_sel = {a[3], a[2]};
      3'd2:    chunk_sel = {a[5], a[4]};
      3'd3:    chunk_sel = {b[0], a[6]};
      3'd4:    chunk_sel = {b[2], b[1]};
      3'd5:    chunk_sel = {b[4], b[3]};
      default: chunk_sel = {b[6], b[5]};
    endcase
  endfunction

  function automatic logic [1:0] clk_sel(input logic [2:0] p);
    case (p)
      3'd0:    clk_sel = 2'b11;
      3'd1:    clk_sel = 2'b00;
      3'd2:    clk_sel = 2'b10;
      3'd3:    clk_sel = 2'b11;
      3'd4:    clk_sel = 2'b01;
      3'd5:    clk_sel = 2'b00;
      default: clk_sel = 2'b11;
    endcase
  endfunction

  assign slot_a   = lock_sync && (ph == PH_SLOT_A);
  assign slot_b   = lock_sync && (ph == PH_SLOT_B);
  assign in_ready = slot_a || slot_b;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_sync <= lock_meta;
    end
  end

  // Holding ph at 6 while unlocked makes the first locked cycle a slot-A cycle.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      ph <= PH_SLOT_A;
    end else if (!lock_sync || ph == PH_SLOT_A) begin
      ph <= lock_sync ? 3'd0 : PH_SLOT_A;
    end else begin
      ph <= ph + 3'd1;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        word_a[l] <= '0;
        word_b[l] <= '0;
      end
    end else begin
      underflow <= (slot_a || slot_b) && !in_valid;
      for (int l = 0; l < LANES; l++) begin
        if (!lock_sync) begin
          word_a[l] <= '0;
          word_b[l] <= '0;
        end else if (slot_a) begin
          word_a[l] <= in_valid ? in_data[7*l +: 7] : IDLE_WORD;
        end else if (slot_b) begin
          word_b[l] <= in_valid ? in_data[7*l +: 7] : IDLE_WORD;
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_clk  <= '0;
    end else if (!lock_sync) begin
      out_data <= '0;
      out_clk  <= '0;
    end else begin
      out_clk <= clk_sel(ph);
      for (int l = 0; l < LANES; l++) begin
        out_data[2*l +: 2] <= chunk_sel(ph, word_a[l], word_b[l]);
      end
    end
  end

endmodule

// File: tb/tb_lvds_7to1_tx_gearbox.sv
// Bench for lvds_7to1_tx_gearbox: a period-level reference model (14-bit serial
// sequence per lane, 14-bit clock pattern) plus directed checks from the test plan.
module tb_lvds_7to1_tx_gearbox;
  localparam int         LANES = 4;
  localparam int         DW    = 7 * LANES;
  localparam int         HW    = DW - 7;
  localparam logic [6:0] IDLE  = 7'h00;

  logic              clkin = 1'b0;
  logic              reset = 1'b0;
  logic              lock = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*LANES-1:0] out_data;
  logic [1:0]        out_clk;
  logic              underflow;

  lvds_7to1_tx_gearbox #(.LANES(LANES), .IDLE_WORD(IDLE)) dut (
    .clkin(clkin), .reset(reset), .lock(lock), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_clk(out_clk), .underflow(underflow)
  );

  always #5 clkin = ~clkin;

  int total = 0;
  int bad = 0;

  // Reference model: each lane's period is a 14-bit sequence S = {B, A}, bit 0 first.
  logic               m_meta, m_sync;
  int                 m_ph;
  logic [13:0]        m_seq [LANES];
  logic [2*LANES-1:0] e_data;
  logic [1:0]         e_clk;
  logic               e_unf;
  logic               e_ready;
  logic [13:0]        clk_pat = 14'b11000111100011; // "1100011" twice, bit 0 first

  assign e_ready = m_sync && (m_ph == 6 || m_ph == 2);

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      m_meta <= 1'b0; m_sync <= 1'b0; m_ph <= 6;
      e_data <= '0; e_clk <= '0; e_unf <= 1'b0;
      for (int l = 0; l < LANES; l++) m_seq[l] <= '0;
    end else begin
      m_meta <= lock;
      m_sync <= m_meta;
      e_unf  <= 1'b0;
      if (!m_sync) begin
        m_ph <= 6; e_data <= '0; e_clk <= '0;
        for (int l = 0; l < LANES; l++) m_seq[l] <= '0;
      end else begin
        m_ph  <= (m_ph + 1) % 7;
        e_clk <= {clk_pat[2*m_ph+1], clk_pat[2*m_ph]};
        for (int l = 0; l < LANES; l++)
          e_data[2*l +: 2] <= 2'((m_seq[l] >> (2 * m_ph)) & 14'h3);
        if (m_ph == 6 || m_ph == 2) begin
          e_unf <= !in_valid;
          for (int l = 0; l < LANES; l++) begin
            if (m_ph == 6) m_seq[l][6:0]  <= in_valid ? in_data[7*l +: 7] : IDLE;
            else           m_seq[l][13:7] <= in_valid ? in_data[7*l +: 7] : IDLE;
          end
        end
      end
    end
  end

  // Upstream source: offers gen_a / gen_b alternately, advancing on each ready cycle.
  logic          next_a = 1'b1;
  logic          rnd = 1'b0;
  logic [DW-1:0] gen_a = '0;
  logic [DW-1:0] gen_b = '0;

  task automatic tick();
    @(posedge clkin);
    #1;
    if (rnd) begin
      in_valid = ($urandom_range(0, 4) != 0);
      in_data  = DW'($urandom);
      if ($urandom_range(0, 79) == 0) lock = !lock;
      else if (!lock && $urandom_range(0, 7) == 0) lock = 1'b1;
    end else if (in_ready) begin
      in_data = next_a ? gen_a : gen_b;
      next_a  = !next_a;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; lock = 1'b0; in_valid = 1'b0; in_data = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    total++;
    if ({out_data, out_clk, underflow, in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state got d=%h c=%b u=%b r=%b want all 0", out_data, out_clk, underflow, in_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({out_data, out_clk, underflow, in_ready} !== '0) begin
        bad++;
        $display("FAIL unlocked_idle got d=%h c=%b u=%b r=%b want all 0", out_data, out_clk, underflow, in_ready);
      end
    end
    lock = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || out_data !== '0 || out_clk !== 2'b00) begin
      bad++;
      $display("FAIL lock_sync_delay got r=%b d=%h c=%b want r=0 d=0 c=00", in_ready, out_data, out_clk);
    end
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lock_first_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_pattern_7f();
    logic [1:0] seen [7];
    logic [1:0] want [7];
    int acc;
    want = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
    acc = 0;
    gen_a = {HW'($urandom), 7'h7F};
    gen_b = {HW'($urandom), 7'h00};
    in_valid = 1'b1;
    for (int c = 0; c < 28; c++) begin
      tick();
      if (in_valid && in_ready) acc++;
      total++;
      if ({out_data, out_clk, underflow, in_ready} !== {e_data, e_clk, e_unf, e_ready}) begin
        bad++;
        $display("FAIL p7f_model c=%0d got d=%h c=%b u=%b r=%b want d=%h c=%b u=%b r=%b",
                 c, out_data, out_clk, underflow, in_ready, e_data, e_clk, e_unf, e_ready);
      end
      if (c >= 14) seen[(m_ph + 6) % 7] = out_data[1:0];
    end
    for (int p = 0; p < 7; p++) begin
      total++;
      if (seen[p] !== want[p]) begin
        bad++;
        $display("FAIL p7f_chunk p%0d got %b want %b", p, seen[p], want[p]);
      end
    end
    total++;
    if (acc != 8) begin
      bad++;
      $display("FAIL accept_rate got %0d accepts in 28 cycles want 8", acc);
    end
  endtask

  task automatic test_alternating();
    gen_a = {HW'($urandom), 7'h55};
    gen_b = {HW'($urandom), 7'h2A};
    for (int c = 0; c < 21; c++) begin
      tick();
      total++;
      if ({out_data, out_clk, underflow, in_ready} !== {e_data, e_clk, e_unf, e_ready}) begin
        bad++;
        $display("FAIL alt_model c=%0d got d=%h c=%b u=%b r=%b want d=%h c=%b u=%b r=%b",
                 c, out_data, out_clk, underflow, in_ready, e_data, e_clk, e_unf, e_ready);
      end
      if (c >= 14) begin
        total++;
        if (out_data[1:0] !== 2'b01) begin
          bad++;
          $display("FAIL alt_chunk c=%0d got %b want 01", c, out_data[1:0]);
        end
      end
    end
  endtask

  task automatic test_clock_free_run();
    logic [1:0] tab [7];
    tab = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
    for (int c = 0; c < 21; c++) begin
      tick();
      total++;
      if (out_clk !== tab[(m_ph + 6) % 7]) begin
        bad++;
        $display("FAIL clk_lane c=%0d got %b want %b", c, out_clk, tab[(m_ph + 6) % 7]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [1:0] want [5];
    int wait_c;
    want = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    gen_a = {HW'($urandom), 7'h7F};
    gen_b = {HW'($urandom), 7'h7F};
    repeat (14) tick();
    wait_c = 0;
    while (!(e_ready && m_ph == 2) && wait_c < 8) begin
      tick();
      wait_c++;
    end
    total++;
    if (!(e_ready && m_ph == 2)) begin
      bad++;
      $display("FAIL uf_wait_slot_b got timeout want slot within 8 cycles");
    end
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_pulse got %b want 1", underflow);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (out_data[1:0] !== want[k] || underflow !== 1'b0) begin
        bad++;
        $display("FAIL uf_chunk k=%0d got d=%b u=%b want d=%b u=0", k, out_data[1:0], underflow, want[k]);
      end
      total++;
      if ({out_data, out_clk, underflow, in_ready} !== {e_data, e_clk, e_unf, e_ready}) begin
        bad++;
        $display("FAIL uf_model k=%0d got d=%h c=%b u=%b r=%b want d=%h c=%b u=%b r=%b",
                 k, out_data, out_clk, underflow, in_ready, e_data, e_clk, e_unf, e_ready);
      end
    end
  endtask

  task automatic test_lock_loss();
    int wait_c;
    gen_a = {HW'($urandom), 7'h7F};
    gen_b = {HW'($urandom), 7'h00};
    wait_c = 0;
    while (m_ph != 4 && wait_c < 8) begin
      tick();
      wait_c++;
    end
    total++;
    if (m_ph != 4) begin
      bad++;
      $display("FAIL ll_wait_ph4 got timeout want ph4 within 8 cycles");
    end
    lock = 1'b0;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ll_ready_drop got %b want 0", in_ready);
    end
    tick();
    total++;
    if (out_data !== '0 || out_clk !== 2'b00 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL ll_outputs_zero got d=%h c=%b u=%b want 0", out_data, out_clk, underflow);
    end
    repeat (3) tick();
    next_a = 1'b1;
    lock = 1'b1;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL relock_ready got %b want 1", in_ready);
    end
    tick();
    tick();
    total++;
    if (out_data[1:0] !== 2'b11 || out_clk !== 2'b11) begin
      bad++;
      $display("FAIL relock_first_word got d=%b c=%b want d=11 c=11", out_data[1:0], out_clk);
    end
    total++;
    if ({out_data, out_clk, underflow, in_ready} !== {e_data, e_clk, e_unf, e_ready}) begin
      bad++;
      $display("FAIL relock_model got d=%h c=%b u=%b r=%b want d=%h c=%b u=%b r=%b",
               out_data, out_clk, underflow, in_ready, e_data, e_clk, e_unf, e_ready);
    end
  endtask

  task automatic test_random();
    rnd = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      total++;
      if ({out_data, out_clk, underflow, in_ready} !== {e_data, e_clk, e_unf, e_ready}) begin
        bad++;
        $display("FAIL rand_model c=%0d got d=%h c=%b u=%b r=%b want d=%h c=%b u=%b r=%b",
                 c, out_data, out_clk, underflow, in_ready, e_data, e_clk, e_unf, e_ready);
      end
    end
    rnd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern_7f();
    test_alternating();
    test_clock_free_run();
    test_underflow();
    test_lock_loss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
